// File: rtl/parking_pkg.sv
// parking_pkg: shared capacity default and active-low 7-segment encodings (g..a in bits 6..0)
package parking_pkg;
  localparam int CAPACITY_DEFAULT = 25;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_F = 7'b0001110;
  localparam logic [6:0] SEG_U = 7'b1000001;
  localparam logic [6:0] SEG_L = 7'b1000111;
  localparam logic [9:0][6:0] SEG_DIGIT = {
    7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
    7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };
endpackage

// File: rtl/seg7.sv
// seg7: decimal digit plus blank flag to active-low 7-segment pattern
module seg7
  import parking_pkg::*;
(
  input  logic [3:0] i_digit,
  input  logic       i_blank,
  output logic [6:0] o_seg
);
  always_comb o_seg = (i_blank || i_digit > 4'd9) ? SEG_BLANK : SEG_DIGIT[i_digit];
endmodule

// File: rtl/parking_occupancy.sv
// parking_occupancy: edge-detected entry/exit counter with saturation, sticky error and 4-digit display
module parking_occupancy
  import parking_pkg::*;
#(
  parameter int CAPACITY = CAPACITY_DEFAULT
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       en,
  input  logic       ex,
  output logic [4:0] count,
  output logic       full,
  output logic       empty,
  output logic       err,
  output logic [6:0] HEX3,
  output logic [6:0] HEX2,
  output logic [6:0] HEX1,
  output logic [6:0] HEX0
);
  localparam logic [4:0] CAP = 5'(CAPACITY);
  logic r_en_q, r_en_qq, r_ex_q, r_ex_qq;
  logic [4:0] r_count;
  logic r_err;
  logic w_in, w_out;
  logic [3:0] w_tens, w_ones;
  logic [6:0] w_seg3, w_seg2, w_seg1, w_seg0;
  assign w_in  = r_en_q & ~r_en_qq;
  assign w_out = r_ex_q & ~r_ex_qq;
  always_ff @(posedge clk) begin
    if (Reset) begin
      r_en_q  <= 1'b0;
      r_en_qq <= 1'b0;
      r_ex_q  <= 1'b0;
      r_ex_qq <= 1'b0;
      r_count <= 5'd0;
      r_err   <= 1'b0;
    end else begin
      r_en_q  <= en;
      r_en_qq <= r_en_q;
      r_ex_q  <= ex;
      r_ex_qq <= r_ex_q;
      if (w_in && !w_out) begin
        if (r_count == CAP) r_err <= 1'b1;
        else r_count <= r_count + 5'd1;
      end else if (w_out && !w_in) begin
        if (r_count == 5'd0) r_err <= 1'b1;
        else r_count <= r_count - 5'd1;
      end
    end
  end
  assign count  = r_count;
  assign err    = r_err;
  assign full   = r_count == CAP;
  assign empty  = r_count == 5'd0;
  assign w_tens = 4'(r_count / 5'd10);
  assign w_ones = 4'(r_count % 5'd10);
  seg7 u_seg3 (.i_digit(4'd0),   .i_blank(1'b1),             .o_seg(w_seg3));
  seg7 u_seg2 (.i_digit(4'd0),   .i_blank(1'b1),             .o_seg(w_seg2));
  seg7 u_seg1 (.i_digit(w_tens), .i_blank(r_count < 5'd10),  .o_seg(w_seg1));
  seg7 u_seg0 (.i_digit(w_ones), .i_blank(1'b0),             .o_seg(w_seg0));
  assign HEX3 = full ? SEG_F : w_seg3;
  assign HEX2 = full ? SEG_U : w_seg2;
  assign HEX1 = full ? SEG_L : w_seg1;
  assign HEX0 = full ? SEG_L : w_seg0;
endmodule
